// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 4:1 mux: steps the select, waits SETTLE cycles per
// channel, samples the mux output and presents a 4-bit frame on valid/ready.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// SETTLE | select held, counting settle cycles, capture on the last one
// HOLD   | frame valid, waiting for the consumer handshake
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic [1:0] sel,
  input  logic       mux_o,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LP_CNT_LAST = CW'(SETTLE - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [2:0]    r_shadow;
  logic [3:0]    r_frame;
  logic          r_frame_valid;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_sel_nxt;
  logic [2:0]    w_shadow_nxt;
  logic [3:0]    w_frame_nxt;
  logic          w_valid_nxt;
  logic          w_busy_nxt;
  logic          w_capture;

  assign w_capture = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_shadow      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sel         <= w_sel_nxt;
      r_shadow      <= w_shadow_nxt;
      r_frame       <= w_frame_nxt;
      r_frame_valid <= w_valid_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = r_frame;
    w_valid_nxt  = r_frame_valid;
    w_busy_nxt   = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (w_capture) begin
          w_cnt_nxt = '0;
          case (r_sel)
            2'd0: begin
              w_shadow_nxt[0] = mux_o;
              w_sel_nxt       = 2'd1;
            end
            2'd1: begin
              w_shadow_nxt[1] = mux_o;
              w_sel_nxt       = 2'd2;
            end
            2'd2: begin
              w_shadow_nxt[2] = mux_o;
              w_sel_nxt       = 2'd3;
            end
            default: begin
              w_frame_nxt = {mux_o, r_shadow};
              w_valid_nxt = 1'b1;
              w_sel_nxt   = '0;
              w_state_nxt = ST_HOLD;
            end
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        // frame itself is left untouched so it keeps its last value
        if (r_frame_valid && frame_ready) begin
          w_valid_nxt = 1'b0;
          if (cont) begin
            w_state_nxt = ST_SETTLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign sel         = r_sel;
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign busy        = r_busy;

endmodule
